// File: rtl/key_event_decoder_if.sv
// Key gesture interface: debounced key level in, gesture pulses and FSM state out.
// Handshake: none. key_down_i is a level sampled every clock. The pulse outputs are
// registered, last exactly one clock, and are never high at the same time.
interface key_event_decoder_if;
    logic       key_down_i;
    logic       single_o;
    logic       double_o;
    logic       long_o;
    logic       repeat_o;
    logic       busy_o;
    logic [2:0] state_o;

    // Driver side: supplies the key level and observes the gesture pulses.
    modport master (
        output key_down_i,
        input  single_o,
        input  double_o,
        input  long_o,
        input  repeat_o,
        input  busy_o,
        input  state_o
    );

    // Decoder side.
    modport slave (
        input  key_down_i,
        output single_o,
        output double_o,
        output long_o,
        output repeat_o,
        output busy_o,
        output state_o
    );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into single click, double click and long press,
// with optional auto-repeat pulses while a long press is held.
module key_event_decoder #(
    parameter int CLK_FREQ  = 100000000,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input logic                clk_i,
    input logic                rst_n_i,
    key_event_decoder_if.slave kif
);

    localparam int TICKS    = CLK_FREQ / 1000;
    localparam int PW       = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int MS_MAX_A = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
    localparam int MS_MAX   = (MS_MAX_A > REPEAT_MS) ? MS_MAX_A : REPEAT_MS;
    localparam int MW       = $clog2(MS_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS - 1);
    localparam logic [MW-1:0] MS_SAT      = MW'(MS_MAX);
    localparam logic [MW-1:0] LONG_LAST   = MW'(LONG_MS - 1);
    localparam logic [MW-1:0] DCLICK_LAST = MW'(DCLICK_MS - 1);
    localparam logic [MW-1:0] REPEAT_LAST = MW'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
    localparam bit            REPEAT_EN   = (REPEAT_MS > 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT2     = 3'd2,
        ST_PRESS2    = 3'd3,
        ST_LONG_HOLD = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MW-1:0]   ms_q, ms_d;
    logic            key_q, key_d;
    logic            armed_q, armed_d;
    logic            single_q, single_d;
    logic            double_q, double_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;
    logic            busy_q, busy_d;

    logic            press_ev;
    logic            rel_ev;
    logic            ms_tick;
    logic            restart;

    // Next-state, pulse and timebase computation.
    always_comb begin
        // A key held through reset is ignored until it has been seen released once.
        press_ev = kif.key_down_i & ~key_q & armed_q;
        rel_ev   = ~kif.key_down_i & key_q;
        ms_tick  = (presc_q == PRESC_LAST);

        key_d    = kif.key_down_i;
        armed_d  = armed_q | ~kif.key_down_i;
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        restart  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press_ev) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                // Release has priority over a coincident long-press threshold.
                if (rel_ev) begin
                    state_d = ST_WAIT2;
                end else if (ms_tick && (ms_q == LONG_LAST)) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG_HOLD;
                end
            end
            ST_WAIT2: begin
                // A second press on the timeout cycle still counts as a double click.
                if (press_ev) begin
                    state_d = ST_PRESS2;
                end else if (ms_tick && (ms_q == DCLICK_LAST)) begin
                    single_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (rel_ev) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_LONG_HOLD: begin
                if (rel_ev) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_EN && ms_tick && (ms_q == REPEAT_LAST)) begin
                    repeat_d = 1'b1;
                    restart  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timebase restarts on every state change and at each repeat period.
        if ((state_d != state_q) || restart) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (ms_tick) begin
            presc_d = '0;
            ms_d    = (ms_q == MS_SAT) ? ms_q : ms_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
            ms_d    = ms_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, timebase and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            ms_q     <= '0;
            key_q    <= 1'b0;
            armed_q  <= 1'b0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            key_q    <= key_d;
            armed_q  <= armed_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            busy_q   <= busy_d;
        end
    end

    assign kif.single_o = single_q;
    assign kif.double_o = double_q;
    assign kif.long_o   = long_q;
    assign kif.repeat_o = repeat_q;
    assign kif.busy_o   = busy_q;
    assign kif.state_o  = state_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: 10 cycles/ms, long = 20 ms, double-click
// gap = 5 ms. Instance a repeats every 4 ms; instance b has repeat disabled.
module tb_key_event_decoder;

    localparam logic [3:0] P_SGL = 4'b0001;
    localparam logic [3:0] P_DBL = 4'b0010;
    localparam logic [3:0] P_LNG = 4'b0100;
    localparam logic [3:0] P_REP = 4'b1000;
    localparam logic [3:0] P_NON = 4'b0000;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [3:0]  a_hot;
    logic [3:0]  b_hot;

    key_event_decoder_if kif_a ();
    key_event_decoder_if kif_b ();

    key_event_decoder #(
        .CLK_FREQ (10000),
        .LONG_MS  (20),
        .DCLICK_MS(5),
        .REPEAT_MS(4)
    ) u_dut_a (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .kif    (kif_a)
    );

    key_event_decoder #(
        .CLK_FREQ (10000),
        .LONG_MS  (20),
        .DCLICK_MS(5),
        .REPEAT_MS(0)
    ) u_dut_b (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .kif    (kif_b)
    );

    // Clock and edge counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every cycle in which any pulse of either instance is high.
    always @(negedge clk) begin
        a_hot = {kif_a.repeat_o, kif_a.long_o, kif_a.double_o, kif_a.single_o};
        b_hot = {kif_b.repeat_o, kif_b.long_o, kif_b.double_o, kif_b.single_o};
        if ((a_hot | b_hot) != 4'b0000)
            obs_q.push_back({b_hot, a_hot, cyc[23:0]});
    end

    function automatic logic [31:0] ev(input logic [3:0] b, input logic [3:0] a, input int c);
        return {b, a, c[23:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare logged pulses against the expected queue, then clear both.
    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_event"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Driver: after 'gap' cycles since the last change, set the key level; returns
    // the clock edge number at which the DUT samples the new level.
    task automatic drive(input bit on_b, input logic v, input int gap, output int edge_cyc);
        repeat (gap) @(negedge clk);
        if (on_b) kif_b.key_down_i = v;
        else      kif_a.key_down_i = v;
        edge_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int tp, tr, tp2, tr2;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        kif_a.key_down_i = 1'b0;
        kif_b.key_down_i = 1'b0;

        // Reset state.
        idle(5);
        check("reset_outputs",
              {22'd0, kif_a.single_o, kif_a.double_o, kif_a.long_o, kif_a.repeat_o, kif_a.busy_o,
               kif_b.single_o, kif_b.double_o, kif_b.long_o, kif_b.repeat_o, kif_b.busy_o},
              32'd0);
        rst_n = 1'b1;
        idle(5);
        obs_q.delete();

        // 1: single click, pulse 50 cycles after release.
        drive(0, 1'b1, 1, tp);
        drive(0, 1'b0, 50, tr);
        exp_q.push_back(ev(P_NON, P_SGL, tr + 50));
        idle(100);
        check_events("t1_single");
        check("t1_busy_idle", 32'(kif_a.busy_o), 32'd0);

        // 2: double click.
        drive(0, 1'b1, 1, tp);
        drive(0, 1'b0, 30, tr);
        drive(0, 1'b1, 20, tp2);
        drive(0, 1'b0, 30, tr2);
        exp_q.push_back(ev(P_NON, P_DBL, tr2));
        idle(100);
        check_events("t2_double");
        check("t2_busy_idle", 32'(kif_a.busy_o), 32'd0);

        // 3: long press with two repeats.
        drive(0, 1'b1, 1, tp);
        idle(250);
        check("t3_busy_hold", 32'(kif_a.busy_o), 32'd1);
        drive(0, 1'b0, 50, tr);
        exp_q.push_back(ev(P_NON, P_LNG, tp + 200));
        exp_q.push_back(ev(P_NON, P_REP, tp + 240));
        exp_q.push_back(ev(P_NON, P_REP, tp + 280));
        idle(100);
        check_events("t3_long");
        check("t3_busy_idle", 32'(kif_a.busy_o), 32'd0);

        // 4: second press lands on the double-click timeout edge.
        drive(0, 1'b1, 1, tp);
        drive(0, 1'b0, 30, tr);
        drive(0, 1'b1, 50, tp2);
        drive(0, 1'b0, 10, tr2);
        exp_q.push_back(ev(P_NON, P_DBL, tr2));
        idle(100);
        check_events("t4_press_wins");
        check("t4_busy_idle", 32'(kif_a.busy_o), 32'd0);

        // 5: reset mid-press with the key still held, then a normal click.
        drive(0, 1'b1, 1, tp);
        idle(50);
        rst_n = 1'b0;
        #1;
        check("t5_reset_busy", 32'(kif_a.busy_o), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(400);
        check("t5_held_ignored", 32'(kif_a.busy_o), 32'd0);
        drive(0, 1'b0, 1, tr);
        idle(100);
        check_events("t5_abort");
        drive(0, 1'b1, 5, tp);
        drive(0, 1'b0, 30, tr);
        exp_q.push_back(ev(P_NON, P_SGL, tr + 50));
        idle(100);
        check_events("t5_click");

        // 6: long press on the instance without repeat.
        drive(1, 1'b1, 1, tp);
        drive(1, 1'b0, 500, tr);
        exp_q.push_back(ev(P_LNG, P_NON, tp + 200));
        idle(100);
        check_events("t6_no_repeat");
        check("t6_busy_idle", 32'(kif_b.busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
